// File: rtl/sl2_arbiter_if.sv
// Bus bundle for sl2_arbiter: two request channels, the shared SL2
// operand/result pair, the response channel and the busy flag.
// The arbiter takes the slave modport; its environment takes the master modport.
interface sl2_arbiter_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = IN_W + 2
);
    logic             req0_valid;
    logic [IN_W-1:0]  req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [IN_W-1:0]  req1_data;
    logic             req1_ready;
    logic [IN_W-1:0]  sl2_a;
    logic [OUT_W-1:0] sl2_s;
    logic             rsp_valid;
    logic [OUT_W-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_ready;
    logic             busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, sl2_s, rsp_ready,
        output req0_ready, req1_ready, sl2_a, rsp_valid, rsp_data, rsp_id, busy
    );

    // Requesters, shared SL2 and response consumer side
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, sl2_s, rsp_ready,
        input  req0_ready, req1_ready, sl2_a, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/sl2_arbiter.sv
// sl2_arbiter: shares one external shift-left-2 unit between two requesters.
// Round-robin grant in IDLE, one settle cycle in ISSUE while the shared SL2
// evaluates the held operand, then the registered result waits in RESP until
// the consumer takes it.
module sl2_arbiter #(
    parameter int IN_W  = 16,
    parameter int OUT_W = IN_W + 2
) (
    input  logic          clk,
    input  logic          reset,
    sl2_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]       state;
    logic             rr_ptr;
    logic             id_reg;
    logic [IN_W-1:0]  sl2_a_q;
    logic             rsp_valid_q;
    logic [OUT_W-1:0] rsp_data_q;
    logic             rsp_id_q;
    logic             grant0;
    logic             grant1;

    // Grant selection: a lone requester always wins, a tie goes to rr_ptr
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid && (!bus.req1_valid || !rr_ptr)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // Control FSM plus operand, ID and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            id_reg      <= 1'b0;
            sl2_a_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (grant0) begin
                        sl2_a_q <= bus.req0_data;
                        id_reg  <= 1'b0;
                        rr_ptr  <= 1'b1;
                        state   <= ISSUE;
                    end else if (grant1) begin
                        sl2_a_q <= bus.req1_data;
                        id_reg  <= 1'b1;
                        rr_ptr  <= 1'b0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_data_q  <= bus.sl2_s;
                    rsp_id_q    <= id_reg;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.sl2_a      = sl2_a_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.busy       = (state != IDLE);

endmodule
